// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick scheduler: board clock, config payload
// and the frequency-to-half-period conversion.
package tick_pkg;

  localparam int unsigned CLK_HZ_BOARD = 100_000_000;
  localparam int unsigned TICK_DIV_W   = 27;

  typedef struct packed {
    logic [TICK_DIV_W-1:0] half;
    logic                  en;
  } tick_cfg_t;

  // Half-period reload value (cycles minus one) for a target frequency.
  function automatic int unsigned hz_to_half(input int unsigned hz,
                                             input int unsigned clk_hz = CLK_HZ_BOARD);
    return clk_hz / (2 * hz) - 1;
  endfunction

  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? 32'($clog2(n_ch)) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Runtime configuration port of the tick scheduler (valid/ready request channel).
interface tick_scheduler_if import tick_pkg::*; #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = TICK_DIV_W
);
  localparam int unsigned CH_W = ch_w(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_half, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, cfg_en, output cfg_ready);

endinterface

// File: rtl/tick_channel.sv
// One clock-enable channel: half-period counter, square wave, rising-edge strobe
// and a single-entry shadow config that lands at the next toggle boundary.
module tick_channel import tick_pkg::*; #(
  parameter int unsigned      DIV_W      = TICK_DIV_W,
  parameter logic [DIV_W-1:0] RESET_HALF = '0,
  parameter logic             RESET_EN   = 1'b1
) (
  input  logic      clk_in,
  input  logic      reset,
  input  logic      wr,
  input  tick_cfg_t wr_cfg,
  output logic      clk_out,
  output logic      tick,
  output logic      pending
);

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] half, half_nxt;
  logic             en, en_nxt;
  logic             clk_out_nxt;
  logic             pending_nxt;
  tick_cfg_t        shadow, shadow_nxt;

  // Next-state: a disabled channel adopts a pending config at once, an enabled
  // one only at terminal count so the running half-period is never cut short.
  always_comb begin
    cnt_nxt     = cnt;
    half_nxt    = half;
    en_nxt      = en;
    clk_out_nxt = clk_out;
    pending_nxt = pending;
    shadow_nxt  = shadow;

    if (wr) begin
      shadow_nxt  = wr_cfg;
      pending_nxt = 1'b1;
    end

    if (!en) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      if (pending) begin
        half_nxt    = DIV_W'(shadow.half);
        en_nxt      = shadow.en;
        pending_nxt = 1'b0;
      end
    end else if (cnt == half) begin
      cnt_nxt = '0;
      if (pending) begin
        half_nxt    = DIV_W'(shadow.half);
        en_nxt      = shadow.en;
        pending_nxt = 1'b0;
        clk_out_nxt = shadow.en & ~clk_out;
      end else begin
        clk_out_nxt = ~clk_out;
      end
    end else begin
      cnt_nxt = cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt     <= '0;
      half    <= RESET_HALF;
      en      <= RESET_EN;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      shadow  <= '0;
    end else begin
      cnt     <= cnt_nxt;
      half    <= half_nxt;
      en      <= en_nxt;
      clk_out <= clk_out_nxt;
      tick    <= clk_out_nxt & ~clk_out;
      pending <= pending_nxt;
      shadow  <= shadow_nxt;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// N_CH programmable clock-enable channels with a shared valid/ready config port;
// this level only decodes the target channel and steers the write strobes.
module tick_scheduler import tick_pkg::*; #(
  parameter int unsigned     CLK_HZ     = CLK_HZ_BOARD,
  parameter int unsigned     N_CH       = 4,
  parameter int unsigned     DEFAULT_HZ = 60,
  parameter logic [N_CH-1:0] RESET_EN   = '1,
  parameter int unsigned     DIV_W      = TICK_DIV_W
) (
  input  logic             clk_in,
  input  logic             reset,
  tick_scheduler_if.slave  cfg,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  localparam int unsigned      CH_W       = ch_w(N_CH);
  localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(hz_to_half(DEFAULT_HZ, CLK_HZ));

  logic            ready;
  logic [N_CH-1:0] wr;
  tick_cfg_t       wr_cfg;

  // Out-of-range channel numbers match nothing, so they are always ready and dropped.
  always_comb begin
    ready = 1'b1;
    wr    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready = ~pending[i];
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr[i] = cfg.cfg_valid & ready & (cfg.cfg_ch == CH_W'(i));
    end
  end

  assign cfg.cfg_ready = ready;
  assign wr_cfg        = '{half: TICK_DIV_W'(cfg.cfg_half), en: cfg.cfg_en};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_channel #(
      .DIV_W      (DIV_W),
      .RESET_HALF (RESET_HALF),
      .RESET_EN   (RESET_EN[i])
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .wr      (wr[i]),
      .wr_cfg  (wr_cfg),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed and randomized checks of tick_scheduler against a countdown reference model.
module tb_tick_scheduler;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned N       = 5;
  localparam int unsigned DEF_HZ  = 50;
  localparam bit [N-1:0]  RST_EN  = 5'b10111;
  localparam int unsigned DEF_HALF = CLK_HZ / (2 * DEF_HZ) - 1;   // 9 -> period 20

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] clk_out, tick, pending;

  tick_scheduler_if #(.N_CH(N), .DIV_W(27)) bus ();

  tick_scheduler #(
    .CLK_HZ(CLK_HZ), .N_CH(N), .DEFAULT_HZ(DEF_HZ), .RESET_EN(RST_EN), .DIV_W(27)
  ) dut (
    .clk_in(clk), .reset(rst), .cfg(bus), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining edges until the next toggle, counted down.
  bit [N-1:0]  m_lvl, m_tck, m_pend, m_en, m_sh_en;
  int unsigned m_half [N];
  int unsigned m_rem [N];
  int unsigned m_sh_half [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int unsigned ch);
    return (ch >= N) ? 1'b1 : ~m_pend[ch];
  endfunction

  task automatic m_apply(input int i);
    m_half[i] = m_sh_half[i];
    m_en[i]   = m_sh_en[i];
    m_pend[i] = 1'b0;
  endtask

  task automatic model_advance(input bit v, input int unsigned ch, input int unsigned h,
                               input bit e, input bit r);
    bit acc;
    bit nl;
    acc = v && m_ready(ch);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_lvl[i] = 0; m_tck[i] = 0; m_pend[i] = 0;
        m_en[i] = RST_EN[i]; m_half[i] = DEF_HALF; m_rem[i] = DEF_HALF + 1;
      end else begin
        nl = m_lvl[i];
        if (!m_en[i]) begin
          nl = 0;
          if (m_pend[i]) m_apply(i);
          m_rem[i] = m_half[i] + 1;
        end else if (m_rem[i] == 1) begin
          if (m_pend[i]) begin
            m_apply(i);
            nl = m_en[i] ? ~m_lvl[i] : 1'b0;
          end else begin
            nl = ~m_lvl[i];
          end
          m_rem[i] = m_half[i] + 1;
        end else begin
          m_rem[i]--;
        end
        m_tck[i] = nl & ~m_lvl[i];
        m_lvl[i] = nl;
        if (acc && ch == i) begin
          m_sh_half[i] = h; m_sh_en[i] = e; m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check ready, advance at posedge, check outputs at negedge.
  task automatic step(input bit v, input int unsigned ch, input int unsigned h, input bit e,
                      input bit r, output bit acc);
    bus.cfg_valid = v;
    bus.cfg_ch    = 3'(ch);
    bus.cfg_half  = 27'(h);
    bus.cfg_en    = e;
    rst           = r;
    #1;
    check("cfg_ready", 32'(bus.cfg_ready), 32'(m_ready(ch)));
    acc = v && bus.cfg_ready;
    @(posedge clk);
    model_advance(v, ch, h, e, r);
    @(negedge clk);
    check("clk_out", 32'(clk_out), 32'(m_lvl));
    check("tick",    32'(tick),    32'(m_tck));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, a);
  endtask

  // Steps until tick[ch]; n = steps taken, or limit+1 on timeout.
  task automatic wait_tick(input int ch, input int limit, output int n);
    bit a;
    n = 0;
    do begin
      step(0, 0, 0, 0, 0, a);
      n++;
    end while (!tick[ch] && n <= limit);
  endtask

  // Length of the current run of clk_out[ch] == lvl, counting the current sample.
  task automatic measure(input int ch, input bit lvl, output int n);
    bit a;
    n = 1;
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0, 0, 0, a);
      if (clk_out[ch] != lvl) break;
      n++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (pending != '0 && k < limit) begin idle(1); k++; end
    check("pending_drain", 32'(pending), 32'(0));
  endtask

  initial begin
    bit a;
    bit [3:0] accs;
    int n;
    int t1, t2;
    bit any_tick;

    bus.cfg_valid = 0; bus.cfg_ch = '0; bus.cfg_half = '0; bus.cfg_en = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_advance(0, 0, 0, 0, 1);

    // Reset state and default-rate first rise / period on ch0.
    check("rst_clk_out", 32'(clk_out), 32'(0));
    check("rst_tick",    32'(tick),    32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_ready",   32'(bus.cfg_ready), 32'(1));
    wait_tick(0, 40, t1);
    wait_tick(0, 40, t2);
    check("t1_first_rise", 32'(t1), 32'(10));
    check("t1_period",     32'(t2), 32'(20));

    // Disable ch1, then re-enable with half=4 from the disabled state.
    step(1, 1, 7, 0, 0, a);
    check("t2_acc_dis", 32'(a), 32'(1));
    wait_idle(40);
    idle(3);
    check("t2_ch1_off", 32'(clk_out[1]), 32'(0));
    step(1, 1, 4, 1, 0, a);
    check("t2_pend_set", 32'(pending[1]), 32'(1));
    idle(1);
    check("t2_pend_clr", 32'(pending[1]), 32'(0));
    wait_tick(1, 20, n);
    check("t2_first_rise", 32'(n), 32'(5));
    wait_tick(1, 20, n);
    check("t2_period", 32'(n), 32'(10));

    // Mid-period shrink to half=1: old high phase completes, then 2-cycle phases.
    step(1, 1, 1, 1, 0, a);
    measure(1, 1'b1, n);
    check("t3_old_high", 32'(n + 1), 32'(5));
    measure(1, 1'b0, n);
    check("t3_new_low", 32'(n), 32'(2));
    measure(1, 1'b1, n);
    check("t3_new_high", 32'(n), 32'(2));

    // Disable while high: falls at next TC and stays low; disabling again is silent.
    wait_tick(1, 10, n);
    step(1, 1, 1, 0, 0, a);
    measure(1, 1'b1, n);
    check("t4_high_len", 32'(n + 1), 32'(2));
    any_tick = 0;
    for (int k = 0; k < 8; k++) begin idle(1); any_tick |= tick[1]; end
    check("t4_held_low", 32'(clk_out[1]), 32'(0));
    step(1, 1, 1, 0, 0, a);
    for (int k = 0; k < 6; k++) begin idle(1); any_tick |= tick[1] | clk_out[1]; end
    check("t4_no_pulse", 32'(any_tick), 32'(0));

    // Back-to-back requests to ch2 stall; out-of-range channels are swallowed.
    step(1, 2, 2, 1, 0, a);
    check("t5_first_acc", 32'(a), 32'(1));
    step(1, 2, 3, 1, 0, a);
    check("t5_second_stall", 32'(a), 32'(0));
    n = 0;
    while (!a && n < 40) begin step(1, 2, 3, 1, 0, a); n++; end
    check("t5_second_acc", 32'(a), 32'(1));
    step(1, 5, 0, 0, 0, a);
    check("t5_oor5_acc", 32'(a), 32'(1));
    step(1, 7, 2, 1, 0, a);
    check("t5_oor7_acc", 32'(a), 32'(1));
    wait_idle(60);
    step(1, 0, 3, 1, 0, a); accs[0] = a;
    step(1, 1, 3, 1, 0, a); accs[1] = a;
    step(1, 2, 3, 1, 0, a); accs[2] = a;
    step(1, 4, 3, 1, 0, a); accs[3] = a;
    check("t5_multi_acc", 32'(accs), 32'(4'hF));

    // Reset with a config still pending.
    wait_idle(60);
    step(1, 0, 6, 1, 0, a);
    check("t6_pend_before", 32'(pending[0]), 32'(1));
    step(0, 0, 0, 0, 1, a);
    check("t6_pending", 32'(pending), 32'(0));
    check("t6_clk_out", 32'(clk_out), 32'(0));
    wait_tick(0, 40, n);
    check("t6_resume_rise", 32'(n), 32'(10));

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 5),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
